// File: rtl/fetch_controller_pkg.sv
// fetch_controller_pkg
//   Shared types and constants for the instruction-fetch sequencer.
//   - fetch_state_e : sequencer FSM states (BOOT, RUN, HALT)
//   - ifid_op_e     : per-cycle command to the IF/ID register
//   - NOP_INSTR     : word loaded into IF/ID for a bubble
package fetch_controller_pkg;

    localparam int PC_W_DEFAULT  = 32;
    localparam int DEPTH_DEFAULT = 32;

    // All-zero decodes as an R-type ADD, so consumers must gate on valid.
    localparam logic [PC_W_DEFAULT-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        IFID_HOLD   = 2'd0,
        IFID_LOAD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } ifid_op_e;

endpackage

// File: rtl/fetch_controller_if.sv
// fetch_controller_if
//   Bundles the fetch sequencer's control inputs, ROM bus and IF/ID outputs.
//   master : the fetch controller (drives pc/ROM address/IF/ID/status)
//   slave  : the environment (hazard unit, EX redirect, ROM, ID stage)
interface fetch_controller_if #(
    parameter int N = 32
);
    logic         stall;
    logic         flush;
    logic         redirect_valid;
    logic [N-1:0] redirect_target;
    logic [N-1:0] rom_address;
    logic [N-1:0] rom_instruction;
    logic [N-1:0] pc;
    logic [N-1:0] if_id_instr;
    logic [N-1:0] if_id_pc;
    logic [N-1:0] if_id_pc_plus1;
    logic         if_id_valid;
    logic         halted;
    logic [N-1:0] fetch_count;
    logic [N-1:0] bubble_count;

    modport master (
        input  stall, flush, redirect_valid, redirect_target, rom_instruction,
        output rom_address, pc, if_id_instr, if_id_pc, if_id_pc_plus1,
               if_id_valid, halted, fetch_count, bubble_count
    );

    modport slave (
        output stall, flush, redirect_valid, redirect_target, rom_instruction,
        input  rom_address, pc, if_id_instr, if_id_pc, if_id_pc_plus1,
               if_id_valid, halted, fetch_count, bubble_count
    );
endinterface

// File: rtl/fetch_controller_if_id_reg.sv
// fetch_controller_if_id_reg
//   IF/ID pipeline register. One command per cycle:
//     HOLD   : all fields keep their value
//     LOAD   : capture instr_in / pc_in / pc_in+1, valid=1
//     BUBBLE : instr=NOP, valid=0, pc fields keep their value
//   Ports: clk, rst_n (async low), op, instr_in, pc_in ->
//          instr, pc, pc_plus1, valid
module fetch_controller_if_id_reg
    import fetch_controller_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  ifid_op_e     op,
    input  logic [N-1:0] instr_in,
    input  logic [N-1:0] pc_in,
    output logic [N-1:0] instr,
    output logic [N-1:0] pc,
    output logic [N-1:0] pc_plus1,
    output logic         valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr    <= '0;
            pc       <= '0;
            pc_plus1 <= '0;
            valid    <= 1'b0;
        end else begin
            case (op)
                IFID_LOAD: begin
                    instr    <= instr_in;
                    pc       <= pc_in;
                    pc_plus1 <= pc_in + N'(1);
                    valid    <= 1'b1;
                end
                IFID_BUBBLE: begin
                    instr <= N'(NOP_INSTR);
                    valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller
//   Instruction-fetch sequencer. Owns the PC, addresses the combinational
//   ROM (rom_address = pc) and feeds IF/ID. Applies redirect > stall >
//   flush > normal each RUN cycle and parks in HALT once pc runs past the
//   ROM; only an in-range redirect restarts fetch.
//   Ports: clk, rst_n (async low), bus (fetch_controller_if.master):
//     in : stall, flush, redirect_valid, redirect_target, rom_instruction
//     out: rom_address, pc, if_id_instr/pc/pc_plus1/valid, halted,
//          fetch_count, bubble_count
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter int N        = 32,
    parameter int DEPTH    = 32,
    parameter int RESET_PC = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_controller_if.master  bus
);

    // One extra bit so DEPTH = 2^N is still representable.
    localparam logic [N:0] DEPTH_X = (N+1)'(DEPTH);

    fetch_state_e state_q, state_d;
    logic [N-1:0] pc_q, pc_d;
    logic [N-1:0] fetch_q, bubble_q;
    ifid_op_e     op;
    logic         pc_oor;
    logic         target_ok;

    assign pc_oor    = ({1'b0, pc_q} >= DEPTH_X);
    assign target_ok = ({1'b0, bus.redirect_target} < DEPTH_X);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_BOOT;
            pc_q     <= N'(RESET_PC);
            fetch_q  <= '0;
            bubble_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            if (op == IFID_LOAD)   fetch_q  <= fetch_q + N'(1);
            if (op == IFID_BUBBLE) bubble_q <= bubble_q + N'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        op      = IFID_HOLD;
        case (state_q)
            // One settle cycle for the ROM; nothing enters IF/ID.
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (bus.redirect_valid) begin
                    // Redirect beats stall; an out-of-range target is caught
                    // by the pc_oor check on the following cycle.
                    pc_d = bus.redirect_target;
                    op   = IFID_BUBBLE;
                end else if (pc_oor) begin
                    // Never load the word past the ROM end; pc parks here.
                    state_d = ST_HALT;
                    op      = bus.stall ? IFID_HOLD : IFID_BUBBLE;
                end else if (bus.stall) begin
                    op = IFID_HOLD;
                end else if (bus.flush) begin
                    pc_d = pc_q + N'(1);
                    op   = IFID_BUBBLE;
                end else begin
                    pc_d = pc_q + N'(1);
                    op   = IFID_LOAD;
                end
            end
            ST_HALT: begin
                if (bus.redirect_valid) begin
                    pc_d = bus.redirect_target;
                    op   = IFID_BUBBLE;
                    if (target_ok) state_d = ST_RUN;
                end else if (!bus.stall) begin
                    op = IFID_BUBBLE;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    fetch_controller_if_id_reg #(.N(N)) u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .op       (op),
        .instr_in (bus.rom_instruction),
        .pc_in    (pc_q),
        .instr    (bus.if_id_instr),
        .pc       (bus.if_id_pc),
        .pc_plus1 (bus.if_id_pc_plus1),
        .valid    (bus.if_id_valid)
    );

    assign bus.rom_address  = pc_q;
    assign bus.pc           = pc_q;
    assign bus.halted       = (state_q == ST_HALT);
    assign bus.fetch_count  = fetch_q;
    assign bus.bubble_count = bubble_q;

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

    localparam int N     = 32;
    localparam int DEPTH = 32;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    fetch_controller_if #(.N(N)) bus();

    fetch_controller #(.N(N), .DEPTH(DEPTH), .RESET_PC(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM: word i = 0xA000_0000 + i, zero beyond the end.
    function automatic logic [N-1:0] rom_word(input logic [N-1:0] a);
        return (a < DEPTH) ? (32'hA000_0000 + a) : '0;
    endfunction

    assign bus.rom_instruction = rom_word(bus.rom_address);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
        // not a shared helper for comparisons; see inline checks below
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.stall = 0; bus.flush = 0; bus.redirect_valid = 0; bus.redirect_target = '0;
        #12;
        total++; if (bus.pc !== 32'd0) $display("FAIL reset_pc got %0d exp 0", bus.pc); else passed++;
        total++; if (bus.if_id_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", bus.if_id_valid); else passed++;
        total++; if (bus.halted !== 1'b0) $display("FAIL reset_halted got %b exp 0", bus.halted); else passed++;
        total++; if (bus.fetch_count !== 32'd0 || bus.bubble_count !== 32'd0)
            $display("FAIL reset_counts got %0d/%0d exp 0/0", bus.fetch_count, bus.bubble_count); else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_free_run();
        step();  // BOOT -> RUN, nothing loaded
        total++; if (bus.pc !== 32'd0 || bus.if_id_valid !== 1'b0)
            $display("FAIL boot_idle got pc=%0d valid=%b exp pc=0 valid=0", bus.pc, bus.if_id_valid); else passed++;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (bus.if_id_pc !== i || bus.if_id_valid !== 1'b1 || bus.if_id_instr !== 32'hA000_0000 + i
                         || bus.if_id_pc_plus1 !== i + 1)
                $display("FAIL run_word%0d got pc=%0d instr=%h valid=%b p1=%0d exp pc=%0d instr=%h valid=1 p1=%0d",
                         i, bus.if_id_pc, bus.if_id_instr, bus.if_id_valid, bus.if_id_pc_plus1,
                         i, 32'hA000_0000 + i, i + 1);
            else passed++;
        end
        total++; if (bus.fetch_count !== 32'd4) $display("FAIL run_fetch_count got %0d exp 4", bus.fetch_count); else passed++;
    endtask

    task automatic test_stall();
        step();  // word 4 loaded, pc=5
        bus.stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (bus.pc !== 32'd5 || bus.if_id_pc !== 32'd4 || bus.if_id_instr !== 32'hA000_0004)
                $display("FAIL stall_hold%0d got pc=%0d ifpc=%0d instr=%h exp 5/4/a0000004",
                         i, bus.pc, bus.if_id_pc, bus.if_id_instr);
            else passed++;
        end
        total++; if (bus.fetch_count !== 32'd5 || bus.bubble_count !== 32'd0)
            $display("FAIL stall_counts got %0d/%0d exp 5/0", bus.fetch_count, bus.bubble_count); else passed++;
        bus.stall = 0;
        step();  // word 5, pc=6
    endtask

    task automatic test_redirect();
        bus.redirect_valid = 1; bus.redirect_target = 32'd9;
        step();
        bus.redirect_valid = 0;
        total++; if (bus.pc !== 32'd9 || bus.if_id_valid !== 1'b0 || bus.bubble_count !== 32'd1 || bus.if_id_pc !== 32'd5)
            $display("FAIL redir_bubble got pc=%0d valid=%b bub=%0d ifpc=%0d exp 9/0/1/5",
                     bus.pc, bus.if_id_valid, bus.bubble_count, bus.if_id_pc);
        else passed++;
        step();
        total++; if (bus.if_id_pc !== 32'd9 || bus.if_id_instr !== 32'hA000_0009 || bus.if_id_valid !== 1'b1)
            $display("FAIL redir_target got ifpc=%0d instr=%h valid=%b exp 9/a0000009/1",
                     bus.if_id_pc, bus.if_id_instr, bus.if_id_valid);
        else passed++;
    endtask

    task automatic test_redirect_stall();
        bus.redirect_valid = 1; bus.redirect_target = 32'd2; bus.stall = 1;
        step();
        bus.redirect_valid = 0; bus.stall = 0;
        total++; if (bus.pc !== 32'd2 || bus.if_id_valid !== 1'b0 || bus.bubble_count !== 32'd2 || bus.fetch_count !== 32'd7)
            $display("FAIL redir_stall got pc=%0d valid=%b bub=%0d fetch=%0d exp 2/0/2/7",
                     bus.pc, bus.if_id_valid, bus.bubble_count, bus.fetch_count);
        else passed++;
        step();  // word 2, pc=3, fetch=8
    endtask

    task automatic test_flush();
        bus.flush = 1;
        step();
        total++; if (bus.pc !== 32'd4 || bus.if_id_valid !== 1'b0 || bus.if_id_pc !== 32'd2 || bus.bubble_count !== 32'd3)
            $display("FAIL flush got pc=%0d valid=%b ifpc=%0d bub=%0d exp 4/0/2/3",
                     bus.pc, bus.if_id_valid, bus.if_id_pc, bus.bubble_count);
        else passed++;
        bus.redirect_valid = 1; bus.redirect_target = 32'd20;
        step();
        bus.flush = 0; bus.redirect_valid = 0;
        total++; if (bus.pc !== 32'd20 || bus.bubble_count !== 32'd4)
            $display("FAIL flush_redir got pc=%0d bub=%0d exp 20/4", bus.pc, bus.bubble_count); else passed++;
        step();
        total++; if (bus.if_id_pc !== 32'd20 || bus.pc !== 32'd21 || bus.fetch_count !== 32'd9)
            $display("FAIL flush_resume got ifpc=%0d pc=%0d fetch=%0d exp 20/21/9",
                     bus.if_id_pc, bus.pc, bus.fetch_count);
        else passed++;
    endtask

    task automatic test_halt();
        for (int i = 0; i < 11; i++) step();
        total++; if (bus.pc !== 32'd32 || bus.if_id_pc !== 32'd31 || bus.halted !== 1'b0 || bus.fetch_count !== 32'd20)
            $display("FAIL halt_edge got pc=%0d ifpc=%0d halted=%b fetch=%0d exp 32/31/0/20",
                     bus.pc, bus.if_id_pc, bus.halted, bus.fetch_count);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (bus.halted !== 1'b1 || bus.if_id_valid !== 1'b0 || bus.pc !== 32'd32 || bus.bubble_count !== 5 + i)
                $display("FAIL halt_idle%0d got halted=%b valid=%b pc=%0d bub=%0d exp 1/0/32/%0d",
                         i, bus.halted, bus.if_id_valid, bus.pc, bus.bubble_count, 5 + i);
            else passed++;
        end
        bus.stall = 1;
        step();
        bus.stall = 0;
        total++; if (bus.bubble_count !== 32'd7 || bus.halted !== 1'b1)
            $display("FAIL halt_stall got bub=%0d halted=%b exp 7/1", bus.bubble_count, bus.halted); else passed++;
        bus.redirect_valid = 1; bus.redirect_target = 32'd40;
        step();
        total++; if (bus.pc !== 32'd40 || bus.halted !== 1'b1 || bus.bubble_count !== 32'd8)
            $display("FAIL halt_oor_redir got pc=%0d halted=%b bub=%0d exp 40/1/8", bus.pc, bus.halted, bus.bubble_count);
        else passed++;
        bus.redirect_target = 32'd0;
        step();
        bus.redirect_valid = 0;
        total++; if (bus.pc !== 32'd0 || bus.halted !== 1'b0 || bus.bubble_count !== 32'd9)
            $display("FAIL halt_exit got pc=%0d halted=%b bub=%0d exp 0/0/9", bus.pc, bus.halted, bus.bubble_count);
        else passed++;
        step();
        total++; if (bus.if_id_pc !== 32'd0 || bus.if_id_instr !== 32'hA000_0000 || bus.if_id_valid !== 1'b1 || bus.fetch_count !== 32'd21)
            $display("FAIL halt_refetch got ifpc=%0d instr=%h valid=%b fetch=%0d exp 0/a0000000/1/21",
                     bus.if_id_pc, bus.if_id_instr, bus.if_id_valid, bus.fetch_count);
        else passed++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) step();
        total++; if (bus.pc !== 32'd7 || bus.if_id_valid !== 1'b1)
            $display("FAIL pre_reset got pc=%0d valid=%b exp 7/1", bus.pc, bus.if_id_valid); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.pc !== 32'd0 || bus.if_id_valid !== 1'b0 || bus.fetch_count !== 32'd0
                     || bus.bubble_count !== 32'd0 || bus.if_id_pc !== 32'd0 || bus.halted !== 1'b0)
            $display("FAIL async_reset got pc=%0d valid=%b fetch=%0d bub=%0d ifpc=%0d halted=%b exp all 0",
                     bus.pc, bus.if_id_valid, bus.fetch_count, bus.bubble_count, bus.if_id_pc, bus.halted);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_flush();
        test_halt();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
